// File: rtl/dft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dft_frame_buffer
// Purpose  : Streaming framer ahead of the DFT core. Collects FRAME_N samples
//            per frame and emits a new frame every HOP samples (overlap when
//            HOP < FRAME_N). Optional partial-frame flush: FRAME_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module dft_frame_buffer #(
  parameter int DATA_W  = 32,
  parameter int FRAME_N = 8,
  parameter int HOP     = 8,
  parameter int SEQ_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef FRAME_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FRAME_N*DATA_W-1:0]   out_frame,
  output logic [SEQ_W-1:0]            out_seq
);

  localparam int c_HIST_W = (FRAME_N - 1) * DATA_W;
  localparam int c_CNT_W  = $clog2(FRAME_N + 1);
  localparam logic [c_CNT_W-1:0] c_FILL_LEN = c_CNT_W'(FRAME_N);
  localparam logic [c_CNT_W-1:0] c_HOP_LEN  = c_CNT_W'(HOP);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [SEQ_W-1:0]   c_SEQ_ONE  = SEQ_W'(1);

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STEADY = 1'b1
  } state_t;

  state_t                      r_state;
  // The newest FRAME_N-1 samples; the incoming sample completes the window.
  logic [c_HIST_W-1:0]         r_hist;
  logic [c_CNT_W-1:0]          r_cnt;
  logic                        r_out_valid;
  logic [FRAME_N*DATA_W-1:0]   r_out_frame;
  logic [SEQ_W-1:0]            r_out_seq;

  logic                        w_out_free;
  logic                        w_drain;
  logic                        w_accept;
  logic                        w_complete;
  logic [c_CNT_W-1:0]          w_cnt_inc;
  logic [c_CNT_W-1:0]          w_target;
  logic [c_HIST_W-1:0]         w_hist_next;
  logic [FRAME_N*DATA_W-1:0]   w_frame_full;

  assign w_out_free = ~r_out_valid | out_ready;
  assign w_drain    = r_out_valid & out_ready;

`ifdef FRAME_FLUSH_EN
  // Sample just shifted out of r_hist: slot 0 of the full window, needed only
  // when a partial window is flushed.
  logic [DATA_W-1:0]           r_oldest;
  logic                        w_flush_go;

  assign w_flush_go = flush & (r_cnt != '0) & w_out_free;
  assign in_ready   = w_out_free & ~w_flush_go;
`else
  assign in_ready   = w_out_free;
`endif

  assign w_accept     = in_valid & in_ready;
  assign w_cnt_inc    = r_cnt + c_CNT_ONE;
  assign w_target     = (r_state == ST_FILL) ? c_FILL_LEN : c_HOP_LEN;
  assign w_complete   = w_accept & (w_cnt_inc == w_target);
  assign w_frame_full = {in_data, r_hist};

  generate
    if (FRAME_N == 2) begin : g_hist_single
      assign w_hist_next = in_data;
    end else begin : g_hist_shift
      assign w_hist_next = {in_data, r_hist[c_HIST_W-1:DATA_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_hist      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_frame <= '0;
      r_out_seq   <= '0;
`ifdef FRAME_FLUSH_EN
      r_oldest    <= '0;
`endif
    end else begin
      if (w_drain) begin
        r_out_seq   <= r_out_seq + c_SEQ_ONE;
        r_out_valid <= 1'b0;
      end
`ifdef FRAME_FLUSH_EN
      if (w_flush_go) begin
        // FILL: unfilled older slots are still zero; STEADY: overlap kept.
        r_out_frame <= {r_hist, r_oldest};
        r_out_valid <= 1'b1;
        r_hist      <= '0;
        r_oldest    <= '0;
        r_cnt       <= '0;
        r_state     <= ST_FILL;
      end else
`endif
      if (w_accept) begin
        r_hist <= w_hist_next;
`ifdef FRAME_FLUSH_EN
        r_oldest <= r_hist[DATA_W-1:0];
`endif
        if (w_complete) begin
          r_out_frame <= w_frame_full;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_STEADY;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_frame = r_out_frame;
  assign out_seq   = r_out_seq;

endmodule
`default_nettype wire

// File: tb/tb_dft_frame_buffer.sv
`default_nettype none
// Bench for dft_frame_buffer: three instances (hop 8, hop 2 with 2-bit seq,
// 2-sample hop 1) checked every cycle against a sample-history model.
module tb_dft_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush_i;

  logic         ir0, ir1, ir2;
  logic         ov0, ov1, ov2;
  logic [255:0] f0, f1;
  logic [63:0]  f2;
  logic [7:0]   s0;
  logic [1:0]   s1;
  logic [2:0]   s2;

  always #5 clk = ~clk;

  dft_frame_buffer #(.DATA_W(32), .FRAME_N(8), .HOP(8), .SEQ_W(8)) u_dut0 (
    .clk(clk), .rst(rst),
`ifdef FRAME_FLUSH_EN
    .flush(flush_i),
`endif
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_frame(f0), .out_seq(s0));

  dft_frame_buffer #(.DATA_W(32), .FRAME_N(8), .HOP(2), .SEQ_W(2)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef FRAME_FLUSH_EN
    .flush(flush_i),
`endif
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_frame(f1), .out_seq(s1));

  dft_frame_buffer #(.DATA_W(32), .FRAME_N(2), .HOP(1), .SEQ_W(3)) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef FRAME_FLUSH_EN
    .flush(flush_i),
`endif
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_frame(f2), .out_seq(s2));

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  // Model: every sample accepted since the last reset/flush, in order.
  logic [31:0]  m_samp  [3][1024];
  int           m_k     [3];
  bit           m_valid [3];
  logic [255:0] m_frame [3];
  int           m_seq   [3];

  function automatic int n_of(int i);
    return (i == 2) ? 2 : 8;
  endfunction
  function automatic int hop_of(int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int seq_mod(int i);
    return (i == 0) ? 256 : ((i == 1) ? 4 : 8);
  endfunction

  function automatic int model_cnt(int i);
    if (m_k[i] < n_of(i)) return m_k[i];
    return (m_k[i] - n_of(i)) % hop_of(i);
  endfunction

  function automatic bit model_flush_go(int i);
    return flush_i && (model_cnt(i) > 0) && (!m_valid[i] || out_ready);
  endfunction

  function automatic bit model_ready(int i);
    return (!m_valid[i] || out_ready) && !model_flush_go(i);
  endfunction

  // Last n samples of the epoch, oldest in slot 0, zero where none exist yet.
  function automatic logic [255:0] window(int i);
    logic [255:0] w = '0;
    for (int s = 0; s < n_of(i); s++) begin
      int idx = m_k[i] - n_of(i) + s;
      if (idx >= 0) w[s*32 +: 32] = m_samp[i][idx];
    end
    return w;
  endfunction

  task automatic model_tick(int i);
    bit drain, fgo, acc;
    if (rst) begin
      m_k[i] = 0; m_valid[i] = 1'b0; m_frame[i] = '0; m_seq[i] = 0;
      return;
    end
    drain = m_valid[i] && out_ready;
    fgo   = model_flush_go(i);
    acc   = in_valid && model_ready(i);
    if (drain) begin
      m_seq[i]   = (m_seq[i] + 1) % seq_mod(i);
      m_valid[i] = 1'b0;
    end
    if (fgo) begin
      m_frame[i] = window(i);
      m_valid[i] = 1'b1;
      m_k[i]     = 0;
    end else if (acc) begin
      if (m_k[i] < 1024) m_samp[i][m_k[i]] = in_data;
      m_k[i] = m_k[i] + 1;
      if (m_k[i] == n_of(i) ||
          (m_k[i] > n_of(i) && (m_k[i] - n_of(i)) % hop_of(i) == 0)) begin
        m_frame[i] = window(i);
        m_valid[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [255:0] dut_frame(int i);
    if (i == 0) return f0;
    if (i == 1) return f1;
    return {192'b0, f2};
  endfunction
  function automatic int dut_seq(int i);
    if (i == 0) return int'(s0);
    if (i == 1) return int'(s1);
    return int'(s2);
  endfunction
  function automatic bit dut_ready(int i);
    return (i == 0) ? ir0 : ((i == 1) ? ir1 : ir2);
  endfunction
  function automatic bit dut_valid(int i);
    return (i == 0) ? ov0 : ((i == 1) ? ov1 : ov2);
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (dut_ready(i) !== model_ready(i)) begin
          n_fail++;
          $display("FAIL in_ready inst%0d t=%0t: got %b expected %b", i, $time, dut_ready(i), model_ready(i));
        end
        n_cmp++;
        if (dut_valid(i) !== m_valid[i]) begin
          n_fail++;
          $display("FAIL out_valid inst%0d t=%0t: got %b expected %b", i, $time, dut_valid(i), m_valid[i]);
        end
        if (m_valid[i]) begin
          n_cmp++;
          if (dut_seq(i) != m_seq[i]) begin
            n_fail++;
            $display("FAIL out_seq inst%0d t=%0t: got %0d expected %0d", i, $time, dut_seq(i), m_seq[i]);
          end
          n_cmp++;
          if (dut_frame(i) !== m_frame[i]) begin
            n_fail++;
            $display("FAIL out_frame inst%0d t=%0t: got %h expected %h", i, $time, dut_frame(i), m_frame[i]);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ramp(int first, int n);
    logic [255:0] w = '0;
    for (int s = 0; s < n; s++) w[s*32 +: 32] = 32'(first + s);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_tick(i);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush_i = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int v;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush_i = 1'b0;
    do_reset();
    cmp_on = 1'b1;
    chk("reset_valid", 256'(ov0), 256'(0));
    chk("reset_ready", 256'(ir0), 256'(1));
    chk("reset_frame", f0, 256'(0));
    chk("reset_seq",   256'(s0), 256'(0));

    // Fill / overlap / seq wrap: stream 1..16 with the consumer always ready.
    for (int d = 1; d <= 16; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
      if (d == 5) begin
        chk("hop1_frame", {192'b0, f2}, ramp(4, 2));
        chk("hop1_seq", 256'(s2), 256'(3));
      end
      if (d == 8) begin
        chk("fill_valid", 256'(ov0), 256'(1));
        chk("fill_frame0", f0, ramp(1, 8));
        chk("fill_seq0", 256'(s0), 256'(0));
        chk("ovl_frame0", f1, ramp(1, 8));
      end
      if (d == 9)  chk("fill_pulse", 256'(ov0), 256'(0));
      if (d == 10) begin
        chk("ovl_frame1", f1, ramp(3, 8));
        chk("ovl_seq1", 256'(s1), 256'(1));
      end
      if (d == 12) begin
        chk("ovl_frame2", f1, ramp(5, 8));
        chk("ovl_seq2", 256'(s1), 256'(2));
      end
      if (d == 16) begin
        chk("fill_frame1", f0, ramp(9, 8));
        chk("fill_seq1", 256'(s0), 256'(1));
        chk("wrap_frame", f1, ramp(9, 8));
        chk("wrap_seq", 256'(s1), 256'(0));
      end
    end
    in_valid = 1'b0;
    step();

    // Back-pressure after the first frame.
    do_reset();
    for (int d = 1; d <= 8; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
    end
    out_ready = 1'b0; in_data = 32'd9;
    for (int c = 0; c < 4; c++) step();
    chk("bp_ready", 256'(ir0), 256'(0));
    chk("bp_hold_frame", f0, ramp(1, 8));
    chk("bp_hold_valid", 256'(ov0), 256'(1));
    out_ready = 1'b1;
    for (int d = 9; d <= 16; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
    end
    chk("bp_next_frame", f0, ramp(9, 8));
    chk("bp_next_seq", 256'(s0), 256'(1));

    // Irregular consumer: source holds each sample until instance 0 takes it.
    pat = 16'b1011_0110_1110_0101;
    v = 17;
    for (int c = 0; c < 400 && v <= 40; c++) begin
      bit acc0;
      out_ready = pat[c % 16];
      in_valid = 1'b1; in_data = 32'(v);
      #1;
      acc0 = model_ready(0);
      step();
      if (acc0) v++;
    end
    if (v <= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL stream_timeout: got sample %0d expected 41", v);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // Reset mid-fill discards the partial window.
    do_reset();
    for (int d = 1; d <= 5; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 20; d <= 27; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
    end
    chk("rst_mid_valid", 256'(ov0), 256'(1));
    chk("rst_mid_frame", f0, ramp(20, 8));
    chk("rst_mid_seq", 256'(s0), 256'(0));
    in_valid = 1'b0;
    step();

`ifdef FRAME_FLUSH_EN
    do_reset();
    for (int d = 1; d <= 3; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
    end
    flush_i = 1'b1; in_data = 32'd99;
    #1;
    chk("flush_ready", 256'(ir0), 256'(0));
    step();
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 256'(ov0), 256'(1));
    chk("flush_frame", f0, {32'd3, 32'd2, 32'd1, 160'd0});
    for (int d = 4; d <= 11; d++) begin
      in_valid = 1'b1; in_data = 32'(d);
      step();
    end
    chk("post_flush_frame", f0, ramp(4, 8));
    chk("post_flush_seq", 256'(s0), 256'(1));
    in_valid = 1'b0;
    step();
`endif

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dft_frame_buffer.md
Name: dft_frame_buffer

Overview:
- Parametrised streaming framer in front of the DFT core.
- Accepts one DATA_W-bit sample per cycle over a valid/ready handshake.
- Assembles FRAME_N-sample frames and emits them as a packed word on a registered valid/ready output.
- Supports overlapping frames through a HOP setting: a new frame is emitted every HOP samples after the first full window. This replaces fixed 8-sample serial loading with back-pressure and configurable overlap.

Parameters:
- DATA_W, 32, sample width in bits.
- FRAME_N, 8, samples per frame; must be ≥ 2.
- HOP, 8, new samples between frames; 1 ≤ HOP ≤ FRAME_N. HOP < FRAME_N gives overlap.
- SEQ_W, 8, width of the frame sequence counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  frame present.
- out_ready  in  1  consumer takes the frame.
- out_frame  out  FRAME_N*DATA_W  packed frame; slice k = out_frame[k*DATA_W +: DATA_W], k=0 oldest sample.
- out_seq  out  SEQ_W  index of emitted frame, wraps modulo 2^SEQ_W.

Behaviour:
- Reset (sync, active-high) clears:
  - outputs: out_valid=0, out_frame=0, out_seq=0, in_ready=1;
  - internals: shift window to 0, sample counter cnt=0, state=FILL.
- Reset asserted mid-frame discards all partial and pending data. No frame is emitted for that partial data.
- Accept event: in_valid & in_ready.
- On accept:
  - the window shifts by one; new sample enters slot FRAME_N-1; slot 0 is dropped;
  - cnt increments.
- in_ready = ~out_valid | out_ready (combinational). Output register can be refilled in the same cycle it is drained.
- State FILL (first window after reset or flush):
  - completes when cnt reaches FRAME_N;
  - that accept loads out_frame with the updated window (including the just-accepted sample), sets out_valid, resets cnt to 0, and moves to STEADY.
- State STEADY:
  - completes when cnt reaches HOP; same load and emit as in FILL.
  - Frame j+1 therefore shares FRAME_N-HOP samples with frame j.
- Latency: out_valid rises the cycle after the completing accept.
- out_valid stays high and out_frame and out_seq stay stable until out_valid & out_ready.
- out_seq increments on each handshake (out_valid & out_ready), wrapping from 2^SEQ_W-1 to 0. out_seq shows the index of the frame currently presented.
- Handshake and completion in the same cycle: the old frame is consumed and the new frame loaded. out_valid stays 1 and out_seq advances by 1.
- Handshake with no completion: out_valid drops to 0.
- in_valid while in_ready=0: the sample is not taken and the window is unchanged. The source must hold it.
- HOP == FRAME_N: non-overlapping frames.
- HOP == 1: a frame is emitted on every accept once STEADY is reached.
- No arithmetic on sample data; samples are passed through bit-exact.

Optional Feature:
- Macro FRAME_FLUSH_EN.
- When defined:
  - adds input port flush (1 bit).
  - flush=1 with cnt>0 and in_ready=1 emits the current partial window as a frame:
    - valid samples are right-justified in the upper slots;
    - unfilled older slots are zero; in STEADY, the retained overlap samples stay in place instead.
  - Then the window and cnt clear and the state returns to FILL.
  - A flush cycle takes no sample even if in_valid=1, and in_ready is forced to 0 that cycle.
  - flush with cnt==0 is ignored.
- When not defined: no flush port and no flush logic; behaviour exactly as above.

Test Plan:
- Fill, defaults (DATA_W=32, FRAME_N=8, HOP=8): stream samples 1..16 with out_ready=1.
  - Two frames: slots 0..7 = 1..8 with out_seq=0, then 9..16 with out_seq=1.
  - out_valid pulses the cycle after samples 8 and 16.
- Overlap, HOP=2: stream 1..12.
  - Frames: 1..8, 3..10, 5..12.
  - out_seq 0, 1, 2.
- Back-pressure: hold out_ready=0 after the first frame while streaming.
  - in_ready drops; the frame stays stable; no sample lost.
  - Release out_ready: next frame = 9..16.
- Reset mid-fill: feed 1..5, assert rst one cycle, feed 20..27.
  - Only frame emitted = 20..27, with out_seq=0.
- Sequence wrap, SEQ_W=2: emit 5 frames.
  - out_seq on handshakes = 0, 1, 2, 3, 0.
- FRAME_FLUSH_EN: feed 1..3 then flush.
  - Frame = 0,0,0,0,0,1,2,3.
  - in_ready=0 in the flush cycle; the next 8 samples form a fresh full frame.
